muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand width in bits (legal 4..64).
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand/dividend; sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  multiplier/divisor; sampled with start.
REQ-008 SHALL have port: cancel  input  1  abort the operation in progress.
REQ-009 SHALL have port: busy  output  1  high in RUN and FIN.
REQ-010 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port: hi  output  WIDTH  product upper half / remainder.
REQ-012 SHALL have port: lo  output  WIDTH  product lower half / quotient.
REQ-013 SHALL have port: div0  output  1  divide-by-zero flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIN; IDLE->RUN on start&!cancel; RUN->FIN after WIDTH iterations; FIN->IDLE unconditionally.
REQ-015 SHALL perform one radix-2 iteration per RUN cycle: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-016 SHALL apply sign fix-up in FIN: signed product sign = a[MSB]^b[MSB]; quotient sign = a^b; remainder sign = sign of a.
REQ-017 SHALL, for start accepted at edge T0, hold RUN during cycles T1..T(WIDTH), FIN during T(WIDTH+1), and present done=1, busy=0 and valid hi/lo in cycle T(WIDTH+2).
REQ-018 SHALL write {hi,lo} = full 2*WIDTH product for mult/multu; hi = remainder and lo = quotient for div/divu.
REQ-019 SHALL hold hi, lo and div0 stable from completion until the next completed operation.
REQ-020 SHALL ignore start while busy; SHALL accept start in the same cycle done is high.
REQ-021 SHALL, on cancel in RUN or FIN, return to IDLE at the next edge with no done pulse and hi/lo/div0 unchanged.
REQ-022 SHALL ignore start when cancel is high in the same cycle.
REQ-023 SHALL produce lo = -2^(WIDTH-1) and hi = 0 for signed -2^(WIDTH-1) / -1 (wrap, no flag).
REQ-024 SHALL produce hi:lo = 2^(2*WIDTH-2) for signed -2^(WIDTH-1) * -2^(WIDTH-1).

Reset
REQ-025 SHALL, while rst is high, force state IDLE, iteration counter 0, busy=0, done=0, div0=0, hi=0, lo=0, independent of clk.
REQ-026 SHALL abort any operation on rst mid-operation; no done pulse follows reset release.

Configuration
REQ-027 SHALL compile division-by-zero detection in when macro MULDIV_DIV0_EN is defined.
REQ-028 SHALL, with MULDIV_DIV0_EN defined, on div/divu with b==0, skip RUN (IDLE->FIN), assert done at T2 with hi=a, lo=all-ones, div0=1; div0 SHALL clear on the next completion.
REQ-029 SHALL, without MULDIV_DIV0_EN, tie div0 to 0 and run the normal WIDTH+2 cycle sequence for b==0, with hi/lo contents unspecified.

Verification
REQ-030 SHALL verify (WIDTH=32): mult a=0xFFFFFFFF b=2 -> hi=0xFFFFFFFF lo=0xFFFFFFFE, done exactly 34 cycles after start edge.
REQ-031 SHALL verify: multu a=0xFFFFFFFF b=2 -> hi=0x00000001 lo=0xFFFFFFFE; div a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
REQ-032 SHALL verify: divu a=100 b=7 -> lo=0x0000000E hi=0x00000002; div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-033 SHALL verify: prior result hi=0x2 lo=0xE; start divu, cancel at T5 -> no done, hi/lo stay 0x2/0xE, busy=0 at T6; start re-pulsed during busy -> ignored.
REQ-034 SHALL verify: MULDIV_DIV0_EN defined, div a=0x1234 b=0 -> done at T2, hi=0x1234, lo=0xFFFFFFFF, div0=1; undefined -> done at T34, div0=0.
REQ-035 SHALL verify: WIDTH=8, mult a=0x80 b=0x80 -> hi=0x40 lo=0x00, done at T10; rst asserted at T4 -> busy=0 immediately, no done.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle for muldiv_unit.
//   master (requester): drives start, op, a, b, cancel; receives busy, done, hi, lo, div0.
//   slave  (muldiv_unit): the mirror image.
//   WIDTH must match the WIDTH of the attached muldiv_unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;      // 00 mult, 01 multu, 10 div, 11 divu
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, div0
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, div0
  );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiplier / restoring divider, one bit per cycle.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - muldiv_unit_if.slave: start/op/a/b/cancel in, busy/done/hi/lo/div0 out
//
// Operation: a start accepted in IDLE loads operand magnitudes and enters RUN for WIDTH
// iterations, then FIN applies the sign fix-up and writes hi/lo, pulsing done in the
// following cycle. mult/multu give {hi,lo} = a*b; div/divu give hi = remainder,
// lo = quotient (truncating, remainder takes the sign of a). cancel aborts RUN/FIN with
// the previous result left intact.
//
// Build option: define MULDIV_DIV0_EN to detect divide-by-zero. Then div/divu with b == 0
// go straight to FIN and complete with hi = a, lo = all-ones, div0 = 1. Without it div0
// is tied low and b == 0 runs the normal sequence with an unspecified result.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int unsigned    CntW     = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  // acc_q: running product high half / partial remainder.
  // lsw_q: multiplier shifting out, product low half / dividend shifting out, quotient in.
  // opnd_q: multiplicand or divisor magnitude.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] lsw_q;
  logic [WIDTH-1:0] opnd_q;
  logic             is_div_q;
  logic             neg_main_q;   // negate product or quotient in FIN
  logic             neg_rem_q;    // negate remainder in FIN
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // ---------------------------------------------------------------------------
  // Request decode and operand magnitudes
  // ---------------------------------------------------------------------------
  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div0_hit;

  assign op_signed = ~bus.op[0];
  assign op_div    = bus.op[1];
  assign a_neg     = op_signed & bus.a[WIDTH-1];
  assign b_neg     = op_signed & bus.b[WIDTH-1];
  // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;

`ifdef MULDIV_DIV0_EN
  assign div0_hit = op_div & (bus.b == '0);
`else
  assign div0_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  // Multiply: add multiplicand when the current multiplier bit is set, then shift the
  // whole {carry, acc, lsw} right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_lsw;

  assign mul_sum = {1'b0, acc_q} + (lsw_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
  assign mul_acc = mul_sum[WIDTH:1];
  assign mul_lsw = {mul_sum[0], lsw_q[WIDTH-1:1]};

  // Divide (restoring): shift next dividend bit into the remainder and subtract the
  // divisor if it fits. The remainder never exceeds WIDTH bits, so the difference is
  // only needed modulo 2^WIDTH.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_lsw;

  assign div_shift = {acc_q, lsw_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  assign div_acc   = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_lsw   = {lsw_q[WIDTH-2:0], div_ge};

  // ---------------------------------------------------------------------------
  // Sign fix-up applied in FIN
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign prod_raw = {acc_q, lsw_q};
  assign prod_fix = neg_main_q ? -prod_raw : prod_raw;
  assign quot_fix = neg_main_q ? -lsw_q : lsw_q;
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;
  assign res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Control and datapath state
  // ---------------------------------------------------------------------------
`ifdef MULDIV_DIV0_EN
  logic div0_pend_q;
  logic div0_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      lsw_q       <= '0;
      opnd_q      <= '0;
      is_div_q    <= 1'b0;
      neg_main_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
`ifdef MULDIV_DIV0_EN
      div0_pend_q <= 1'b0;
      div0_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.cancel) begin
            cnt_q    <= '0;
            is_div_q <= op_div;
            busy_q   <= 1'b1;
            if (div0_hit) begin
              // Skip RUN; FIN passes acc/lsw through unchanged.
              state_q     <= StFin;
              acc_q       <= bus.a;
              lsw_q       <= '1;
              opnd_q      <= bus.b;
              neg_main_q  <= 1'b0;
              neg_rem_q   <= 1'b0;
`ifdef MULDIV_DIV0_EN
              div0_pend_q <= 1'b1;
`endif
            end else begin
              state_q    <= StRun;
              acc_q      <= '0;
              neg_main_q <= a_neg ^ b_neg;
              neg_rem_q  <= a_neg;
              if (op_div) begin
                lsw_q  <= a_mag;
                opnd_q <= b_mag;
              end else begin
                lsw_q  <= b_mag;
                opnd_q <= a_mag;
              end
`ifdef MULDIV_DIV0_EN
              div0_pend_q <= 1'b0;
`endif
            end
          end
        end

        StRun: begin
          if (bus.cancel) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= is_div_q ? div_acc : mul_acc;
            lsw_q <= is_div_q ? div_lsw : mul_lsw;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == LastIter) begin
              state_q <= StFin;
            end
          end
        end

        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!bus.cancel) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
`ifdef MULDIV_DIV0_EN
            div0_q <= div0_pend_q;
`endif
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIV0_EN
  assign bus.div0 = div0_q;
`else
  assign bus.div0 = 1'b0;
`endif

endmodule
